uart_tx_io: RTL

// Memory-mapped UART transmitter on the processor's I/O bus, beside the io block in the upper (>=256) data space.
// The processor writes bytes into a small FIFO; an 8N1 serializer drains them onto a single tx line.
// A status register lets firmware poll for space before writing, so no interrupt is needed.

---
 rtl/uart_tx_io.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped UART transmitter on the processor I/O bus.
// Firmware pushes bytes into a small TX FIFO through the TXDATA register and
// polls STATUS for space; an 8N1 serializer drains the FIFO onto the tx line.
//
// Registers (io_addr):
//   0 TXDATA  write pushes io_data_in[7:0]; reads as 0
//   1 STATUS  [0] full, [1] empty, [2] busy, [3] overflow (sticky),
//             [7:4] FIFO count, [8] parity present; a write clears overflow
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit is sent between the data bits and the
//   stop bit (11 bit times per frame) and STATUS[8] reads 1.

module uart_tx_io #(
    parameter int WIDTH      = 32,
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_addr,
    input  logic             io_w_en,
    input  logic [WIDTH-1:0] io_data_in,
    output logic [WIDTH-1:0] io_data_out,
    output logic             tx,
    output logic             busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    // Even parity of a byte: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic          full_s;
    logic          empty_s;
    logic          push_req_s;
    logic          push_ok_s;
    logic          status_wr_s;
    logic          pop_s;
    logic [7:0]    head_s;
    logic          data_unused_s;

    assign full_s        = (count_r == COUNT_FULL);
    assign empty_s       = (count_r == {CW{1'b0}});
    assign push_req_s    = io_w_en & ~io_addr;
    // A push into a full FIFO still fits when the serializer pops on the same edge.
    assign push_ok_s     = push_req_s & (~full_s | pop_s);
    assign status_wr_s   = io_w_en & io_addr;
    assign head_s        = mem_r[rd_ptr_r];
    assign data_unused_s = ^io_data_in[WIDTH-1:8];

    // FIFO data array: written only by accepted pushes, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= io_data_in[7:0];
        end
    end

    // FIFO pointers, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (status_wr_s) begin
                overflow_r <= 1'b0;
            end else if (push_req_s && !push_ok_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t      state_r;
    state_t      state_s;
    logic [15:0] baud_cnt_r;
    logic [15:0] baud_cnt_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_s;
    logic        tx_r;
    logic        tx_s;
    logic        baud_done_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
    logic        parity_s;
`endif

    assign baud_done_s = (baud_cnt_r == 16'd0);

    // Next-state logic; tx_s is the line level for the state being entered so
    // the registered tx changes on the same edge as the state.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        tx_s       = tx_r;
        pop_s      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    shift_s    = head_s;
                    baud_cnt_s = BAUD_LOAD;
                    bit_idx_s  = 3'd0;
                    tx_s       = 1'b0;
                    state_s    = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_s   = even_parity(head_s);
`endif
                end else begin
                    tx_s       = 1'b1;
                    baud_cnt_s = 16'd0;
                end
            end
            S_START: begin
                if (baud_done_s) begin
                    baud_cnt_s = BAUD_LOAD;
                    tx_s       = shift_r[0];
                    state_s    = S_DATA;
                end else begin
                    baud_cnt_s = baud_cnt_r - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_done_s) begin
                    baud_cnt_s = BAUD_LOAD;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_s    = parity_r;
                        state_s = S_PARITY;
`else
                        tx_s    = 1'b1;
                        state_s = S_STOP;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done_s) begin
                    baud_cnt_s = BAUD_LOAD;
                    tx_s       = 1'b1;
                    state_s    = S_STOP;
                end else begin
                    baud_cnt_s = baud_cnt_r - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_done_s) begin
                    // Back-to-back frames: pop the next byte on the stop-bit end edge.
                    if (!empty_s) begin
                        pop_s      = 1'b1;
                        shift_s    = head_s;
                        baud_cnt_s = BAUD_LOAD;
                        bit_idx_s  = 3'd0;
                        tx_s       = 1'b0;
                        state_s    = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_s   = even_parity(head_s);
`endif
                    end else begin
                        baud_cnt_s = 16'd0;
                        tx_s       = 1'b1;
                        state_s    = S_IDLE;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r - 16'd1;
                end
            end
            default: begin
                state_s    = S_IDLE;
                baud_cnt_s = 16'd0;
                bit_idx_s  = 3'd0;
                tx_s       = 1'b1;
            end
        endcase
    end

    // FSM state, baud timer, shift register and the glitch-free tx register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Bus read path and status outputs
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] status_s;

    // STATUS word assembly and register-select mux for reads.
    always_comb begin
        status_s      = {WIDTH{1'b0}};
        status_s[0]   = full_s;
        status_s[1]   = empty_s;
        status_s[2]   = busy;
        status_s[3]   = overflow_r;
        status_s[7:4] = 4'(count_r);
`ifdef UART_TX_PARITY_EN
        status_s[8]   = 1'b1;
`else
        status_s[8]   = 1'b0;
`endif
        if (io_addr) begin
            io_data_out = status_s;
        end else begin
            io_data_out = {WIDTH{1'b0}};
        end
    end

    assign busy = (state_r != S_IDLE) | ~empty_s;
    assign tx   = tx_r;

endmodule
